// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER memory arbiter.
package otter_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {PORT_F, PORT_D} port_t;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

endpackage

// File: rtl/otter_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// OTTER_ARB_RR_EN selects round-robin on collisions; otherwise D always wins.
module otter_arb_pick (
  input  logic f_req,
  input  logic d_req,
  input  logic last_gnt_d,
  output logic grant_d
);

`ifdef OTTER_ARB_RR_EN
  // On a collision the port that did not go last is served.
  assign grant_d = d_req & (~f_req | ~last_gnt_d);
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_d;
  assign grant_d         = d_req;
`endif

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares the single-port memory between fetch (F) and data (D) requesters and
// steers D accesses at or above IO_BASE onto the IOBUS. Option: OTTER_ARB_RR_EN.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        F_REQ,
  input  logic [31:0] F_ADDR,
  output logic        F_ACK,
  output logic [31:0] F_DATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [3:0]  D_BE,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        MEM_RD,
  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_RDATA,
  input  logic [31:0] IOBUS_IN,
  output logic [31:0] IOBUS_OUT,
  output logic [31:0] IOBUS_ADDR,
  output logic        IOBUS_WR
);

  arb_state_t  state, state_nxt;
  port_t       gnt, last_gnt;
  logic        is_io;
  logic [31:0] io_rdata;
  logic        last_d, pick_d;

  assign last_d = (last_gnt == PORT_D);

  otter_arb_pick u_pick (
    .f_req      (F_REQ),
    .d_req      (D_REQ),
    .last_gnt_d (last_d),
    .grant_d    (pick_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      gnt      <= PORT_F;
      last_gnt <= PORT_F;
      is_io    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (F_REQ || D_REQ)) begin
        gnt   <= pick_d ? PORT_D : PORT_F;
        is_io <= pick_d && (D_ADDR >= IO_BASE);
      end
      if (state == RESP) last_gnt <= gnt;
    end
  end

  // IOBUS_IN is only meaningful while the address is driven in ACCESS.
  always_ff @(posedge CLK) begin
    if (state == ACCESS && is_io) io_rdata <= IOBUS_IN;
  end

  always_comb begin
    state_nxt  = state;
    F_ACK      = 1'b0;
    F_DATA     = '0;
    D_ACK      = 1'b0;
    D_RDATA    = '0;
    MEM_ADDR   = '0;
    MEM_WDATA  = '0;
    MEM_RD     = 1'b0;
    MEM_WE     = 1'b0;
    MEM_BE     = '0;
    IOBUS_OUT  = '0;
    IOBUS_ADDR = '0;
    IOBUS_WR   = 1'b0;
    unique case (state)
      IDLE: begin
        if (F_REQ || D_REQ) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = RESP;
        if (gnt == PORT_F) begin
          MEM_ADDR = F_ADDR;
          MEM_RD   = 1'b1;
        end else if (is_io) begin
          IOBUS_ADDR = D_ADDR;
          IOBUS_WR   = D_WE;
          IOBUS_OUT  = D_WDATA;
        end else begin
          MEM_ADDR  = D_ADDR;
          MEM_RD    = ~D_WE;
          MEM_WE    = D_WE;
          MEM_BE    = D_BE;
          MEM_WDATA = D_WDATA;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        if (gnt == PORT_F) begin
          F_ACK  = 1'b1;
          F_DATA = MEM_RDATA;
        end else begin
          D_ACK = 1'b1;
          if (!D_WE) D_RDATA = is_io ? io_rdata : MEM_RDATA;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A granted requester must hold its request until its ACK cycle.
  a_f_hold: assert property (@(posedge CLK) disable iff (RST)
    (state != IDLE && gnt == PORT_F) |-> F_REQ);
  a_d_hold: assert property (@(posedge CLK) disable iff (RST)
    (state != IDLE && gnt == PORT_D) |-> D_REQ);

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter with a transaction-level reference model.
module tb_otter_mem_arbiter;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;
  localparam logic [31:0] IO_KEY  = 32'h1100_0085;
  localparam int L_NONE = 0, L_MADDR = 1, L_FDATA = 2, L_DRDATA = 3,
                 L_IOADDR = 4, L_FLAGS = 5;

  logic        CLK, RST;
  logic        F_REQ, F_ACK, D_REQ, D_WE, D_ACK;
  logic [31:0] F_ADDR, F_DATA, D_ADDR, D_WDATA, D_RDATA;
  logic [3:0]  D_BE, MEM_BE;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA, IOBUS_IN, IOBUS_OUT, IOBUS_ADDR;
  logic        MEM_RD, MEM_WE, IOBUS_WR;

  otter_mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_ACK(F_ACK), .F_DATA(F_DATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_BE(D_BE),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE),
    .MEM_BE(MEM_BE), .MEM_RDATA(MEM_RDATA),
    .IOBUS_IN(IOBUS_IN), .IOBUS_OUT(IOBUS_OUT), .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_WR(IOBUS_WR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory macro stand-in: synchronous read, byte-enabled write.
  logic [31:0] mac_mem [logic [31:0]];
  always @(posedge CLK) begin
    if (MEM_WE) begin
      logic [31:0] w;
      w = mac_mem.exists(MEM_ADDR) ? mac_mem[MEM_ADDR] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (MEM_BE[b]) w[8*b +: 8] = MEM_WDATA[8*b +: 8];
      mac_mem[MEM_ADDR] = w;
    end
    if (MEM_RD) MEM_RDATA <= mac_mem.exists(MEM_ADDR) ? mac_mem[MEM_ADDR] : 32'h0;
  end

  assign IOBUS_IN = IOBUS_ADDR ^ IO_KEY;

  // Reference model: phase of the current transaction and who owns it.
  logic [31:0] mdl_mem [logic [31:0]];
  int          m_phase;
  bit          m_d, m_io, m_last_d;
  int          checks, errors;
  int          lit_sel;
  logic [31:0] lit_exp;

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
  endfunction

  task automatic lit_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic        e_fack, e_dack, e_mrd, e_mwe, e_iowr;
    logic [31:0] e_fdata, e_drdata, e_maddr, e_mwd, e_ioout, e_ioaddr;
    logic [3:0]  e_mbe;
    logic [200:0] exp_v, act_v;
    {e_fack, e_dack, e_mrd, e_mwe, e_iowr} = '0;
    {e_fdata, e_drdata, e_maddr, e_mwd, e_ioout, e_ioaddr} = '0;
    e_mbe = '0;
    if (m_phase == 1) begin
      if (!m_d) begin
        e_maddr = F_ADDR; e_mrd = 1'b1;
      end else if (m_io) begin
        e_ioaddr = D_ADDR; e_iowr = D_WE; e_ioout = D_WDATA;
      end else begin
        e_maddr = D_ADDR; e_mrd = !D_WE; e_mwe = D_WE; e_mbe = D_BE; e_mwd = D_WDATA;
      end
    end else if (m_phase == 2) begin
      if (!m_d) begin
        e_fack = 1'b1; e_fdata = mdl_rd(F_ADDR);
      end else begin
        e_dack = 1'b1;
        if (!D_WE) e_drdata = m_io ? (D_ADDR ^ IO_KEY) : mdl_rd(D_ADDR);
      end
    end
    exp_v = {e_fack, e_fdata, e_dack, e_drdata, e_maddr, e_mwd, e_mrd, e_mwe, e_mbe,
             e_ioout, e_ioaddr, e_iowr};
    act_v = {F_ACK, F_DATA, D_ACK, D_RDATA, MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WE, MEM_BE,
             IOBUS_OUT, IOBUS_ADDR, IOBUS_WR};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_outputs t=%0t got=%h want=%h", $time, act_v, exp_v);
    end
    case (lit_sel)
      L_MADDR:  lit_chk("lit_mem_addr", MEM_ADDR, lit_exp);
      L_FDATA:  lit_chk("lit_f_data", F_DATA, lit_exp);
      L_DRDATA: lit_chk("lit_d_rdata", D_RDATA, lit_exp);
      L_IOADDR: lit_chk("lit_iobus_addr", IOBUS_ADDR, lit_exp);
      L_FLAGS:  lit_chk("lit_flags", {27'h0, F_ACK, D_ACK, MEM_RD, MEM_WE, IOBUS_WR}, lit_exp);
      default: ;
    endcase
    // Advance the model with the inputs the DUT will sample at the next edge.
    if (m_phase == 1 && m_d && !m_io && D_WE) begin
      logic [31:0] w;
      w = mdl_rd(D_ADDR);
      for (int b = 0; b < 4; b++)
        if (D_BE[b]) w[8*b +: 8] = D_WDATA[8*b +: 8];
      mdl_mem[D_ADDR] = w;
    end
    if (RST) begin
      m_phase = 0; m_last_d = 1'b0;
    end else if (m_phase == 0) begin
      if (F_REQ || D_REQ) begin
`ifdef OTTER_ARB_RR_EN
        m_d = (F_REQ && D_REQ) ? !m_last_d : D_REQ;
`else
        m_d = D_REQ;
`endif
        m_io = m_d && (D_ADDR >= IO_BASE);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_last_d = m_d;
      m_phase = 0;
    end
  end

  task automatic cyc();
    lit_sel = L_NONE;
    @(posedge CLK);
    #1;
  endtask

  task automatic single(input bit isd, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int s1, input logic [31:0] v1,
                        input int s2, input logic [31:0] v2);
    if (isd) begin
      D_REQ = 1'b1; D_WE = we; D_ADDR = addr; D_WDATA = wdata; D_BE = be;
    end else begin
      F_REQ = 1'b1; F_ADDR = addr;
    end
    cyc(); lit_sel = s1; lit_exp = v1;
    cyc(); lit_sel = s2; lit_exp = v2;
    cyc(); F_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
  endtask

  task automatic collide(input bit d_first);
    F_REQ = 1'b1; F_ADDR = 32'h100;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h2000; D_BE = 4'hF;
    cyc();
    cyc(); lit_sel = L_FLAGS; lit_exp = d_first ? 32'b01000 : 32'b10000;
    cyc(); if (d_first) D_REQ = 1'b0; else F_REQ = 1'b0;
    cyc();
    cyc(); lit_sel = L_FLAGS; lit_exp = d_first ? 32'b10000 : 32'b01000;
    cyc(); F_REQ = 1'b0; D_REQ = 1'b0;
  endtask

  initial begin
    m_phase = 0; m_d = 1'b0; m_io = 1'b0; m_last_d = 1'b0;
    checks = 0; errors = 0; lit_sel = L_NONE; lit_exp = '0;
    RST = 1'b1; F_REQ = 1'b0; F_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0; D_BE = '0;
    MEM_RDATA = '0;
    mac_mem[32'h100] = 32'hDEAD_BEEF;      mdl_mem[32'h100] = 32'hDEAD_BEEF;
    mac_mem[32'h2000] = 32'hAABB_CCDD;     mdl_mem[32'h2000] = 32'hAABB_CCDD;
    mac_mem[32'h1100_0020] = 32'hCAFE_F00D; mdl_mem[32'h1100_0020] = 32'hCAFE_F00D;
    mac_mem[32'h10FF_FFFC] = 32'h0BAD_C0DE; mdl_mem[32'h10FF_FFFC] = 32'h0BAD_C0DE;
    cyc();
    cyc(); RST = 1'b0; lit_sel = L_FLAGS; lit_exp = 32'h0;
    cyc();
    single(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, L_MADDR, 32'h100, L_FDATA, 32'hDEAD_BEEF);
    single(1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011,
           L_FLAGS, 32'b00010, L_FLAGS, 32'b01000);
    single(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, L_MADDR, 32'h2000, L_DRDATA, 32'hAABB_5678);
    single(1'b1, 1'b0, 32'h1100_0020, 32'h0, 4'hF,
           L_IOADDR, 32'h1100_0020, L_DRDATA, 32'h0000_00A5);
    single(1'b1, 1'b1, 32'h1100_0020, 32'h55, 4'hF, L_FLAGS, 32'b00001, L_FLAGS, 32'b01000);
    single(1'b0, 1'b0, 32'h1100_0020, 32'h0, 4'h0, L_FLAGS, 32'b00100, L_FDATA, 32'hCAFE_F00D);
    single(1'b1, 1'b0, 32'h10FF_FFFC, 32'h0, 4'hF, L_FLAGS, 32'b00100, L_DRDATA, 32'h0BAD_C0DE);
    single(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, L_FLAGS, 32'b00000, L_DRDATA, 32'hEEFF_FF79);
    single(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, L_NONE, 32'h0, L_FDATA, 32'hDEAD_BEEF);
    collide(1'b1);
    single(1'b1, 1'b0, 32'h10FF_FFFC, 32'h0, 4'hF, L_NONE, 32'h0, L_DRDATA, 32'h0BAD_C0DE);
`ifdef OTTER_ARB_RR_EN
    collide(1'b0);
`else
    collide(1'b1);
`endif
    // Reset while the fetch is in ACCESS; the held request is then reissued.
    F_REQ = 1'b1; F_ADDR = 32'h100;
    cyc(); RST = 1'b1; lit_sel = L_MADDR; lit_exp = 32'h100;
    cyc(); RST = 1'b0; lit_sel = L_FLAGS; lit_exp = 32'h0;
    cyc();
    cyc(); lit_sel = L_FDATA; lit_exp = 32'hDEAD_BEEF;
    cyc(); F_REQ = 1'b0;
    cyc();
    cyc();
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
